// File: rtl/sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sdram_port_arbiter
// Purpose  : Round-robin sharing of one toggle-handshake SDRAM port among N
//            level-request / one-cycle-ack clients, with an access watchdog.
// Revision : 1.0  initial release
// ============================================================================
module sdram_port_arbiter #(
    parameter int N       = 3,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    cl_req,
    input  logic [N-1:0]    cl_we,
    input  logic [23*N-1:0] cl_a,
    input  logic [2*N-1:0]  cl_ds,
    input  logic [16*N-1:0] cl_d,
    output logic [N-1:0]    cl_ack,
    output logic [15:0]     cl_q,
    output logic            mem_req,
    input  logic            mem_ack,
    output logic            mem_we,
    output logic [22:0]     mem_a,
    output logic [1:0]      mem_ds,
    output logic [15:0]     mem_d,
    input  logic [15:0]     mem_q,
    output logic            busy,
    output logic            timeout_err
);
    localparam int          IW      = (N > 1) ? $clog2(N) : 1;
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_SYNC  = 3'd0,
        S_IDLE  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t        state, state_next;
    logic          ack_r;
    logic [IW-1:0] rr, rr_next, gnt, gnt_next, sel;
    logic [15:0]   watchdog, watchdog_next;
    logic [N-1:0]  ack_next;
    logic [15:0]   q_next, d_next;
    logic [22:0]   a_next;
    logic [1:0]    ds_next;
    logic          req_next, we_next, busy_next, terr_next;

    logic [22:0]   a_arr  [N];
    logic [1:0]    ds_arr [N];
    logic [15:0]   d_arr  [N];

    genvar i;
    generate
        for (i = 0; i < N; i++) begin : g_unpack
            assign a_arr[i]  = cl_a[23*i +: 23];
            assign ds_arr[i] = cl_ds[2*i +: 2];
            assign d_arr[i]  = cl_d[16*i +: 16];
        end
    endgenerate

    // Search downward so the nearest requester after rr is the last to write sel.
    always_comb begin
        sel = rr;
        for (int k = N; k >= 1; k--) begin
            if (cl_req[IW'((int'(rr) + k) % N)]) begin
                sel = IW'((int'(rr) + k) % N);
            end
        end
    end

    // Deliberately not reset: after a mid-access reset the true memory-side
    // level must be visible so SYNC can wait for it to settle.
    always_ff @(posedge clk) begin
        ack_r <= mem_ack;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_SYNC;
            rr          <= IW'(N - 1);
            gnt         <= '0;
            watchdog    <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_a       <= '0;
            mem_ds      <= '0;
            mem_d       <= '0;
            cl_ack      <= '0;
            cl_q        <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_next;
            rr          <= rr_next;
            gnt         <= gnt_next;
            watchdog    <= watchdog_next;
            mem_req     <= req_next;
            mem_we      <= we_next;
            mem_a       <= a_next;
            mem_ds      <= ds_next;
            mem_d       <= d_next;
            cl_ack      <= ack_next;
            cl_q        <= q_next;
            busy        <= busy_next;
            timeout_err <= terr_next;
        end
    end

    always_comb begin
        state_next    = state;
        rr_next       = rr;
        gnt_next      = gnt;
        watchdog_next = watchdog;
        req_next      = mem_req;
        we_next       = mem_we;
        a_next        = mem_a;
        ds_next       = mem_ds;
        d_next        = mem_d;
        ack_next      = '0;
        q_next        = cl_q;
        busy_next     = busy;
        terr_next     = 1'b0;

        case (state)
            S_SYNC: begin
                if (ack_r == mem_req) state_next = S_IDLE;
            end
            S_IDLE: begin
                if (|cl_req) begin
                    gnt_next   = sel;
                    rr_next    = sel;
                    we_next    = cl_we[sel];
                    a_next     = a_arr[sel];
                    ds_next    = ds_arr[sel];
                    d_next     = d_arr[sel];
                    busy_next  = 1'b1;
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                req_next      = ~mem_req;
                watchdog_next = '0;
                state_next    = S_WAIT;
            end
            S_WAIT: begin
                // A match on the expiry cycle still counts as a normal completion.
                if (ack_r == mem_req) begin
                    if (!mem_we) q_next = mem_q;
                    ack_next[gnt] = 1'b1;
                    state_next    = S_DONE;
                end else if (watchdog == WD_LAST) begin
                    if (!mem_we) q_next = 16'hFFFF;
                    ack_next[gnt] = 1'b1;
                    terr_next     = 1'b1;
                    busy_next     = 1'b0;
                    state_next    = S_SYNC;
                end else begin
                    watchdog_next = watchdog + 16'd1;
                end
            end
            S_DONE: begin
                busy_next  = 1'b0;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_SYNC;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_port_arbiter
// Purpose  : Directed and randomized self-checking bench for sdram_port_arbiter.
// Revision : 1.0  initial release
// ============================================================================
module tb_sdram_port_arbiter;
    localparam int N       = 3;
    localparam int TIMEOUT = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    cl_req, cl_we, cl_ack;
    logic [23*N-1:0] cl_a;
    logic [2*N-1:0]  cl_ds;
    logic [16*N-1:0] cl_d;
    logic [15:0]     cl_q, mem_d, mem_q;
    logic            mem_req, mem_ack, mem_we, busy, timeout_err;
    logic [22:0]     mem_a;
    logic [1:0]      mem_ds;

    sdram_port_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .cl_req(cl_req), .cl_we(cl_we), .cl_a(cl_a), .cl_ds(cl_ds), .cl_d(cl_d),
        .cl_ack(cl_ack), .cl_q(cl_q),
        .mem_req(mem_req), .mem_ack(mem_ack), .mem_we(mem_we), .mem_a(mem_a),
        .mem_ds(mem_ds), .mem_d(mem_d), .mem_q(mem_q),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;
    int          last_grant;   // reference model: most recently granted client
    logic        model_lvl;    // reference model: expected mem_req level
    logic [15:0] model_q;      // reference model: expected cl_q

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic raise(input int i, input logic we, input logic [22:0] a,
                         input logic [1:0] ds, input logic [15:0] d);
        cl_we[i]          = we;
        cl_a[23*i +: 23]  = a;
        cl_ds[2*i +: 2]   = ds;
        cl_d[16*i +: 16]  = d;
        cl_req[i]         = 1'b1;
    endtask

    task automatic raise_rand(input int i);
        raise(i, 1'($urandom_range(0, 1)), 23'($urandom), 2'($urandom_range(1, 3)), 16'($urandom));
    endtask

    // One complete access with the request vector currently presented.
    // lat: negedges after the toggle before memory acks (<0: never).
    task automatic run_access(input int lat, input logic [15:0] data,
                              output int gi, output int t_tog);
        logic [N-1:0] snap;
        int           g, t;
        logic         e_we, lvl0, e_to, stable;
        logic [22:0]  e_a;
        logic [1:0]   e_ds;
        logic [15:0]  e_d;

        snap = cl_req;
        g = -1;
        for (int k = 1; k <= N; k++) begin
            if (g < 0 && snap[(last_grant + k) % N]) g = (last_grant + k) % N;
        end
        if (g < 0) g = 0;
        e_we = cl_we[g];
        e_a  = cl_a[23*g +: 23];
        e_ds = cl_ds[2*g +: 2];
        e_d  = cl_d[16*g +: 16];

        lvl0 = mem_req;
        t = 0;
        while (mem_req === lvl0 && t < 40) begin
            tick();
            t++;
        end
        t_tog     = t;
        model_lvl = ~model_lvl;
        chk("req_toggle", mem_req, model_lvl);
        chk("busy_on", busy, 1);
        chk("mem_fields", {mem_we, mem_a, mem_ds, mem_d}, {e_we, e_a, e_ds, e_d});

        // A granted client's inputs are ignored while the access is in flight.
        cl_we[g]         = ~e_we;
        cl_a[23*g +: 23] = ~e_a;
        cl_ds[2*g +: 2]  = ~e_ds;
        cl_d[16*g +: 16] = ~e_d;

        e_to   = (lat < 0) || (lat > TIMEOUT - 2);
        stable = 1'b1;
        t = 0;
        while (cl_ack === '0 && t < TIMEOUT + 8) begin
            if (t == lat) begin
                mem_ack = mem_req;
                mem_q   = data;
            end
            tick();
            t++;
            if ({mem_req, mem_we, mem_a, mem_ds, mem_d} !== {model_lvl, e_we, e_a, e_ds, e_d})
                stable = 1'b0;
        end
        chk("ack_latency", t, e_to ? TIMEOUT : lat + 2);
        chk("mem_stable", stable, 1);
        chk("cl_ack", cl_ack, 64'(1) << g);
        chk("timeout_err", timeout_err, e_to);
        if (!e_we) model_q = e_to ? 16'hFFFF : data;
        chk("cl_q", cl_q, model_q);
        chk("busy_at_ack", busy, !e_to);
        gi = -1;
        for (int k = 0; k < N; k++) if (cl_ack[k]) gi = k;

        cl_req[g] = 1'b0;
        tick();
        chk("ack_pulse", {cl_ack, timeout_err, busy}, 0);
        last_grant = g;

        // Memory never answered: arbiter must sit in SYNC until it does.
        if (e_to && mem_ack !== mem_req) begin
            for (int k = 0; k < 5; k++) begin
                chk("sync_hold", {mem_req, busy, cl_ack}, {model_lvl, {(N + 1){1'b0}}});
                tick();
            end
            mem_ack = mem_req;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, observed running expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int gi, tt, r, lat, lvl, t;
        int rr_obs[6];
        int rr_exp[6];
        rr_exp = '{0, 1, 2, 0, 1, 2};

        reset   = 1'b1;
        cl_req  = '0;
        cl_we   = '0;
        cl_a    = '0;
        cl_ds   = '0;
        cl_d    = '0;
        mem_ack = 1'b0;
        mem_q   = 16'h0;
        tick();
        tick();
        chk("reset_outs", {mem_req, cl_ack, cl_q, mem_we, mem_a, mem_ds, mem_d, busy, timeout_err}, 64'h0);
        reset      = 1'b0;
        last_grant = N - 1;
        model_lvl  = 1'b0;
        model_q    = 16'h0;

        // Round-robin with all clients requesting continuously.
        for (int i = 0; i < N; i++) raise_rand(i);
        for (int n = 0; n < 6; n++) begin
            run_access(int'($urandom_range(0, 5)), 16'($urandom), gi, tt);
            rr_obs[n] = gi;
            if (gi >= 0) raise_rand(gi);
        end
        for (int n = 0; n < 6; n++) chk("rr_order", rr_obs[n], rr_exp[n]);
        cl_req = '0;
        tick();
        tick();

        // Single read from client 1.
        raise(1, 1'b0, 23'h001234, 2'b11, 16'h0);
        run_access(6, 16'hBEEF, gi, tt);
        chk("read_grant_latency", tt, 2);
        chk("read_grant", gi, 1);

        // Write passthrough from client 0.
        raise(0, 1'b1, 23'h2F0F0F, 2'b01, 16'hA55A);
        run_access(3, 16'h1357, gi, tt);
        chk("write_grant", gi, 0);

        // Timeout on client 2 while client 0 waits behind it.
        raise(2, 1'b0, 23'h7FFFFF, 2'b10, 16'h0);
        raise(0, 1'b0, 23'h000001, 2'b11, 16'h0);
        run_access(-1, 16'h0, gi, tt);
        chk("timeout_grant", gi, 2);
        run_access(4, 16'h6789, gi, tt);
        chk("sync_to_issue", tt, 4);
        chk("post_timeout_grant", gi, 0);

        // Ack on the watchdog expiry cycle wins; one cycle later times out.
        raise(1, 1'b0, 23'h0000AA, 2'b11, 16'h0);
        run_access(TIMEOUT - 2, 16'hC0DE, gi, tt);
        raise(2, 1'b0, 23'h0000BB, 2'b11, 16'h0);
        run_access(TIMEOUT - 1, 16'hD00D, gi, tt);

        // Reset while an access is pending and memory holds ack high.
        raise(0, 1'b0, 23'h0ABCDE, 2'b11, 16'h0);
        lvl = mem_req;
        t = 0;
        while (mem_req === lvl && t < 10) begin
            tick();
            t++;
        end
        chk("rst_pending_req", mem_req, 1);
        mem_ack = 1'b1;
        reset   = 1'b1;
        tick();
        chk("rst_abort", {mem_req, busy, cl_ack, timeout_err, cl_q}, 0);
        tick();
        reset      = 1'b0;
        model_lvl  = 1'b0;
        model_q    = 16'h0;
        last_grant = N - 1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("rst_sync_hold", {mem_req, busy, cl_ack}, 0);
        end
        mem_ack = 1'b0;
        run_access(3, 16'h4242, gi, tt);
        chk("rst_resume_latency", tt, 4);
        chk("rst_resume_grant", gi, 0);

        // Randomized traffic, including withdrawn requests and timeouts.
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < N; i++) begin
                if (!cl_req[i] && $urandom_range(0, 1) == 1) raise_rand(i);
                else if (cl_req[i] && $urandom_range(0, 7) == 0) cl_req[i] = 1'b0;
            end
            if (cl_req == '0) raise_rand(int'($urandom_range(0, N - 1)));
            r = int'($urandom_range(0, 9));
            lat = (r < 7) ? int'($urandom_range(0, 8)) :
                  (r == 7) ? TIMEOUT - 2 : (r == 8) ? TIMEOUT - 1 : -1;
            run_access(lat, 16'($urandom), gi, tt);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares the SDRAM controller's single toggle-handshake request port among N independent clients (ROM loader, sprite/blitter fetch, sound CPU).
- Each client has a simple level-request / one-cycle-ack interface. The arbiter grants one client at a time in round-robin order and forwards its access as one toggle of `mem_req`.
- It waits for `mem_ack` to match `mem_req` and returns read data to the granted client.
- A watchdog terminates accesses that never complete.

Parameters:
- N, 3, number of clients (2..8).
- TIMEOUT, 255, cycles in WAIT before forced completion (1..65535).

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- cl_req  in  N  per-client request level; held until the matching cl_ack
- cl_we  in  N  per-client write (1) / read (0)
- cl_a  in  23*N  per-client word address [23:1]; client i occupies bits [23*i+22:23*i]
- cl_ds  in  2*N  per-client byte enables {upper, lower}; client i occupies bits [2*i+1:2*i]
- cl_d  in  16*N  per-client write data
- cl_ack  out  N  one-cycle completion pulse, at most one bit set
- cl_q  out  16  read data, valid in the cl_ack cycle (shared by all clients)
- mem_req  out  1  toggle request to the SDRAM port
- mem_ack  in  1  SDRAM port ack; access complete when mem_ack == mem_req
- mem_we  out  1  write strobe, held stable while busy
- mem_a  out  23  word address, held stable while busy
- mem_ds  out  2  byte enables, held stable while busy
- mem_d  out  16  write data, held stable while busy
- mem_q  in  16  SDRAM read data, valid when ack matches
- busy  out  1  high from ISSUE through DONE
- timeout_err  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- Reset values:
  - mem_req=0, cl_ack=0, cl_q=0, mem_we=0, mem_a=0, mem_ds=0, mem_d=0, busy=0, timeout_err=0.
  - rr pointer = N-1, so client 0 wins first.
  - state=SYNC, watchdog=0.
- `mem_ack` is registered once (ack_r) before any comparison. Every match test uses ack_r.
- SYNC state:
  - Go to IDLE when ack_r == mem_req.
  - Otherwise wait. A reset mid-access lands here until the memory side settles.
- IDLE state, when any cl_req bit is set:
  - Grant g = first set bit searching upward from rr+1, wrapping modulo N.
  - Latch cl_we[g], cl_a[g], cl_ds[g], cl_d[g] into the mem_* registers.
  - Set rr=g, set busy=1, go to ISSUE.
  - With no request, stay in IDLE and outputs hold.
- ISSUE state (1 cycle): toggle mem_req, clear watchdog, go to WAIT.
- WAIT state:
  - Watchdog increments each cycle.
  - On ack_r == mem_req:
    - For a read, capture cl_q <= mem_q.
    - Pulse cl_ack[g]=1 for one cycle.
    - Go to DONE.
  - On watchdog == TIMEOUT-1 without a match:
    - Pulse timeout_err and cl_ack[g].
    - For a read, cl_q = 16'hFFFF.
    - Go to SYNC; mem_req is not toggled back.
- DONE state (1 cycle gap): busy=0, go to IDLE.
  - The client must drop cl_req in the cycle after cl_ack. A cl_req still high in IDLE is treated as a new request.
- Latency: IDLE grant to mem_req toggle = 2 edges. Minimum turnaround from cl_req to cl_ack = 4 + SDRAM service cycles + 1 (ack register).
- Round-robin fairness:
  - With all N requesting continuously, grants cycle 0,1,..,N-1,0.
  - No client waits more than N-1 other accesses.
- Client inputs are sampled only in IDLE. Changes to a granted client's a/d/we while busy are ignored.
- cl_req deasserted by a client before grant: that client is simply not granted.
- Simultaneous ack match and watchdog expiry in the same cycle: the match wins and no timeout_err.
- Reset asserted in any state: immediate return to the reset values on the next edge. No cl_ack is issued for the aborted access.

Test Plan:
- Single read: client 1 requests a=23'h001234, ds=2'b11; memory model acks 6 cycles after the toggle with q=16'hBEEF -> mem_req 0→1, mem_a=23'h001234, cl_ack=3'b010 one cycle, cl_q=16'hBEEF.
- Write passthrough: client 0 writes d=16'hA55A, ds=2'b01 -> mem_we=1, mem_d=16'hA55A, mem_ds=2'b01 stable until ack; cl_ack[0] pulses; mem_req toggles exactly once.
- Round-robin: all 3 clients request continuously for 6 accesses -> grant order 0,1,2,0,1,2; each cl_ack is a single pulse.
- Timeout: memory never acks, TIMEOUT=16 -> timeout_err and cl_ack pulse 16 cycles after ISSUE, cl_q=16'hFFFF, state SYNC. Driving ack to match then returns to IDLE and the next request is serviced.
- Reset mid-WAIT: reset while mem_req=1 and ack pending, with the memory model holding ack=1 -> after reset mem_req=0 and ack_r=1, arbiter stays in SYNC and issues nothing. Memory ack forced to 0 -> IDLE, normal service resumes.
- Match/timeout collision: ack arrives exactly on the watchdog expiry cycle -> normal completion, no timeout_err, cl_q = mem_q.
